// File: rtl/cmp_sweep_pkg.sv
//------------------------------------------------------------------------------
// cmp_sweep_pkg : state encoding and sizing helpers for cmp_sweep_checker
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package cmp_sweep_pkg;

    localparam int C_STATE_W = 2;

    typedef enum logic [C_STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Number of (a, b) operand pairs in one exhaustive sweep.
    function automatic int pair_count(input int width);
        return 1 << (2 * width);
    endfunction

endpackage

`default_nettype wire

// File: rtl/cmp_sweep_golden.sv
//------------------------------------------------------------------------------
// cmp_sweep_golden : combinational unsigned reference comparator
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cmp_sweep_golden #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_eq,
    output logic             o_gt,
    output logic             o_lt
);

    assign o_eq = (i_a == i_b);
    assign o_gt = (i_a >  i_b);
    assign o_lt = (i_a <  i_b);

endmodule

`default_nettype wire

// File: rtl/cmp_sweep_checker.sv
//------------------------------------------------------------------------------
// cmp_sweep_checker : exhaustive stimulus/response checker for WIDTH-bit
// magnitude comparators. Optional macro CMP_SWEEP_STOP_ON_ERR_EN ends the
// sweep at the first mismatching pair.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cmp_sweep_checker
    import cmp_sweep_pkg::*;
#(
    parameter int WIDTH     = 5,
    parameter int LAT       = 0,
    parameter int ERR_CNT_W = 11
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic [WIDTH-1:0]     a_out,
    output logic [WIDTH-1:0]     b_out,
    input  logic                 eq_in,
    input  logic                 gt_in,
    input  logic                 lt_in,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [WIDTH-1:0]     first_err_a,
    output logic [WIDTH-1:0]     first_err_b
);

    localparam int                   C_PAIRS    = pair_count(WIDTH);
    localparam logic [2*WIDTH-1:0]   C_LAST_IDX = (2*WIDTH)'(C_PAIRS - 1);
    localparam int                   C_WAIT_W   = (LAT > 0) ? $clog2(LAT + 1) : 1;
    localparam logic [C_WAIT_W-1:0]  C_LAT      = C_WAIT_W'(LAT);
    localparam logic [ERR_CNT_W-1:0] C_ERR_MAX  = '1;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   w_clear;
    logic [WIDTH-1:0]       r_a;
    logic [WIDTH-1:0]       r_b;
    logic [C_WAIT_W-1:0]    r_wait;
    logic [ERR_CNT_W-1:0]   r_err;
    logic [WIDTH-1:0]       r_first_a;
    logic [WIDTH-1:0]       r_first_b;
    logic                   w_gold_eq;
    logic                   w_gold_gt;
    logic                   w_gold_lt;
    logic                   w_sample;
    logic                   w_mis;
    logic                   w_last;
    logic                   w_stop;

    cmp_sweep_golden #(
        .WIDTH (WIDTH)
    ) u_golden (
        .i_a  (r_a),
        .i_b  (r_b),
        .o_eq (w_gold_eq),
        .o_gt (w_gold_gt),
        .o_lt (w_gold_lt)
    );

    assign w_sample = (r_state == ST_RUN) && (r_wait == C_LAT);
    assign w_mis    = w_sample &&
                      ({eq_in, gt_in, lt_in} != {w_gold_eq, w_gold_gt, w_gold_lt});
    // {a, b} doubles as the pair index, so b wraps into a on increment.
    assign w_last   = ({r_a, r_b} == C_LAST_IDX);

`ifdef CMP_SWEEP_STOP_ON_ERR_EN
    assign w_stop = w_mis;
`else
    assign w_stop = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                    w_clear     = 1'b1;
                end
            end
            ST_RUN: begin
                if (w_sample && (w_last || w_stop)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a       <= '0;
            r_b       <= '0;
            r_wait    <= '0;
            r_err     <= '0;
            r_first_a <= '0;
            r_first_b <= '0;
        end else if (w_clear) begin
            r_a       <= '0;
            r_b       <= '0;
            r_wait    <= '0;
            r_err     <= '0;
            r_first_a <= '0;
            r_first_b <= '0;
        end else if (r_state == ST_RUN) begin
            if (w_sample) begin
                r_wait <= '0;
                if (w_mis) begin
                    if (r_err != C_ERR_MAX) begin
                        r_err <= r_err + 1'b1;
                    end
                    // A saturated counter never returns to zero, so zero means "no error yet".
                    if (r_err == '0) begin
                        r_first_a <= r_a;
                        r_first_b <= r_b;
                    end
                end
                if (!w_last && !w_stop) begin
                    {r_a, r_b} <= {r_a, r_b} + 1'b1;
                end
            end else begin
                r_wait <= r_wait + 1'b1;
            end
        end
    end

    assign a_out       = r_a;
    assign b_out       = r_b;
    assign busy        = (r_state == ST_RUN);
    assign done        = (r_state == ST_DONE);
    assign pass        = done && (r_err == '0);
    assign err_count   = r_err;
    assign first_err_a = r_first_a;
    assign first_err_b = r_first_b;

endmodule

`default_nettype wire

// File: doc/cmp_sweep_checker.md
Name: cmp_sweep_checker

Overview:
- Synthesizable, self-checking stimulus/response engine for WIDTH-bit magnitude comparators: the driving-and-checking end of the comparator's a/b → eq/gt/lt interface.
- On start, it sweeps every (a, b) operand pair in order: a outer, b inner, both from 0 to 2^WIDTH-1.
- For each pair it samples the comparator's eq/gt/lt after a fixed latency and checks them against a golden model.
- Reports an error count, the first failing pair and pass/fail; used as on-chip BIST and as a reusable checker in regression benches.

Parameters:
- WIDTH, 5, operand width of the comparator under test.
- LAT, 0, clock cycles between operands becoming valid and the DUT result being valid (0 = combinational DUT).
- ERR_CNT_W, 11, width of the error counter; saturates at all-ones.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  begin a sweep; sampled in IDLE and DONE only.
- a_out  output  WIDTH  operand a to DUT; registered.
- b_out  output  WIDTH  operand b to DUT; registered.
- eq_in  input  1  DUT equal flag.
- gt_in  input  1  DUT greater-than flag.
- lt_in  input  1  DUT less-than flag.
- busy  output  1  high while a sweep is running.
- done  output  1  high in DONE; held until the next start or reset.
- pass  output  1  valid when done=1; 1 iff err_count==0.
- err_count  output  ERR_CNT_W  number of mismatching pairs; saturating.
- first_err_a  output  WIDTH  a of the first mismatching pair.
- first_err_b  output  WIDTH  b of the first mismatching pair.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset (immediate, async): state=IDLE; a_out, b_out, busy, done, pass, err_count, first_err_a, first_err_b, wait counter all 0.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1 → RUN next cycle. Operands = (0,0), wait_cnt=0, err_count=0, first_err cleared, busy=1.
- RUN, pair window: each pair holds for exactly LAT+1 cycles with a_out/b_out stable.
  - wait_cnt counts 0..LAT.
  - When wait_cnt==LAT, the flags are sampled in that cycle and compared (combinational against registered operands).
  - Golden model: eq=(a==b), gt=(a>b), lt=(a<b), unsigned.
  - Mismatch = any of the three flags differs; that pair counts as one error.
- Error recording: err_count increments by 1 per mismatching pair and saturates at 2^ERR_CNT_W-1. On the first mismatch of the sweep, first_err_a/b capture that pair; later mismatches leave them unchanged.
- Advance: after the sample, b increments. When b==2^WIDTH-1, b wraps to 0 and a increments. When a==b==2^WIDTH-1 is sampled → DONE.
- Sweep length: 2^(2·WIDTH)·(LAT+1) cycles in RUN (WIDTH=5, LAT=0: 1024 cycles).
- DONE: busy=0, done=1, pass=(err_count==0); operand outputs hold the last pair. start=1 → RUN with all results cleared, same as from IDLE.
- start during RUN is ignored.
- rst mid-sweep aborts immediately to IDLE; no partial results are retained.

Optional Feature:
- Macro: CMP_SWEEP_STOP_ON_ERR_EN.
- Defined: the first mismatch transitions RUN→DONE on the next edge; err_count=1, pass=0, operands hold the failing pair.
- Undefined: the full sweep always completes and all mismatches are counted.

Decomposition:
- Package cmp_sweep_pkg: state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2); the pair-count constant derived from WIDTH.
- Sub-module cmp_sweep_golden: purely combinational reference comparator (a, b → eq, gt, lt), instantiated once.

Test Plan:
- Correct comparator_5bit, LAT=0, 1-cycle start pulse → busy for 1024 cycles, then done=1, pass=1, err_count=0.
- DUT with gt stuck-at-0 → err_count=496, first_err_a=1, first_err_b=0, pass=0.
- DUT with eq inverted → err_count=1024, first_err=(0,0), pass=0; with ERR_CNT_W=8, err_count=255 (saturated).
- DUT registered one cycle, LAT=1 → 2048 RUN cycles, pass=1; same DUT with LAT=0 → pass=0.
- rst pulsed at RUN cycle 500 → all outputs 0 in the same cycle; the next start completes a clean sweep with pass=1. start held high throughout RUN → no restart; start in DONE → new sweep with err_count cleared.
- CMP_SWEEP_STOP_ON_ERR_EN defined, gt stuck-at-0 → done after pair index 32 (a=1, b=0); err_count=1, a_out=1, b_out=0.
